// File: rtl/rv64g_l2_pkg.sv
// rv64g_l2_pkg: shared types and constants for the L2 MSHR sequencer.
// FSM state encoding, TileLink opcode values and the client-ID helper.
package rv64g_l2_pkg;

    localparam int L2_ADDR_W   = 64;
    localparam int L2_SOURCE_W = 6;
    localparam int L2_TYPE_W   = 3;
    localparam int L2_CORES    = 4;
    localparam int L2_CID_W    = $clog2(L2_CORES);
    localparam int L2_TMO_W    = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIR   = 3'd1,
        ST_DSET  = 3'd2,
        ST_PROBE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_GRANT = 3'd5,
        ST_GACK  = 3'd6
    } l2_state_e;

    // TileLink channel opcodes
    localparam logic [L2_TYPE_W-1:0] TL_ACQUIRE_BLOCK = 3'd6;
    localparam logic [L2_TYPE_W-1:0] TL_ACQUIRE_PERM  = 3'd7;
    localparam logic [L2_TYPE_W-1:0] TL_PROBE         = 3'd6;
    localparam logic [L2_TYPE_W-1:0] TL_PROBE_ACK     = 3'd4;
    localparam logic [L2_TYPE_W-1:0] TL_GRANT         = 3'd4;
    localparam logic [L2_TYPE_W-1:0] TL_GRANT_DATA    = 3'd5;
    localparam logic [L2_TYPE_W-1:0] TL_GRANT_ACK     = 3'd0;

    // The client (core) ID lives in the top bits of the TileLink source.
    function automatic logic [L2_CID_W-1:0] src_to_cid(input logic [L2_SOURCE_W-1:0] src);
        return src[L2_SOURCE_W-1 -: L2_CID_W];
    endfunction

endpackage

// File: rtl/rv64g_l2_prio_enc.sv
// rv64g_l2_prio_enc: lowest-set-bit priority encoder with a found flag.
module rv64g_l2_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv64g_l2_mshr_ctrl.sv
// rv64g_l2_mshr_ctrl: sequencing FSM for one L2 MSHR entry
// (Acquire -> directory lookup -> probes -> Grant -> GrantAck -> dealloc).
// Optional probe timeout is compiled in with L2_MSHR_PROBE_TMO_EN.
//
// state | meaning
// IDLE  | entry free, Acquire accepted when the MSHR can allocate
// DIR   | one-cycle directory lookup request
// DSET  | load probe mask = sharers minus requester
// PROBE | issue probes on B, lowest pending un-issued core first
// WAIT  | all probes issued, wait for pending_probes to drain
// GRANT | Grant on D until accepted
// GACK  | wait for GrantAck, then free the entry
module rv64g_l2_mshr_ctrl
    import rv64g_l2_pkg::*;
#(
    parameter int ADDR_W   = L2_ADDR_W,
    parameter int SOURCE_W = L2_SOURCE_W,
    parameter int TYPE_W   = L2_TYPE_W,
    parameter int CORES    = L2_CORES,
    parameter int CID_W    = $clog2(CORES),
    parameter int TMO_W    = L2_TMO_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                acq_valid_i,
    output logic                acq_ready_o,
    input  logic [ADDR_W-1:0]   acq_addr_i,
    input  logic [SOURCE_W-1:0] acq_source_i,
    input  logic [TYPE_W-1:0]   acq_type_i,
    output logic                mshr_alloc_req_o,
    input  logic                mshr_alloc_ready_i,
    output logic                mshr_set_probes_o,
    output logic [CORES-1:0]    mshr_probes_mask_o,
    output logic                mshr_probe_ack_o,
    output logic [CID_W-1:0]    mshr_probe_ack_id_o,
    input  logic [CORES-1:0]    mshr_pending_i,
    input  logic [SOURCE_W-1:0] mshr_source_i,
    output logic                mshr_dealloc_o,
    output logic                dir_req_o,
    input  logic [CORES-1:0]    dir_sharers_i,
    output logic                b_valid_o,
    input  logic                b_ready_i,
    output logic [CID_W-1:0]    b_core_o,
    input  logic                c_ack_valid_i,
    input  logic [CID_W-1:0]    c_ack_core_i,
    output logic                d_valid_o,
    input  logic                d_ready_i,
    output logic [SOURCE_W-1:0] d_source_o,
    input  logic                e_valid_i,
    output logic                busy_o,
    output logic                timeout_o
);

    l2_state_e        r_state;
    l2_state_e        w_state_nxt;
    logic [CORES-1:0] r_issued;
    logic [CORES-1:0] w_mask;
    logic [CORES-1:0] w_cand;
    logic [CORES-1:0] w_tgt_onehot;
    logic [CID_W-1:0] w_tgt_idx;
    logic             w_tgt_found;
    logic             w_last_probe;
    logic [CID_W-1:0] w_req_cid;
    logic             w_ack_hit;
    logic             w_tmo_hit;
    logic             w_unused;

    // Address and opcode travel with the MSHR entry; the sequencer never needs them.
    assign w_unused = ^{acq_addr_i, acq_type_i};

    assign w_req_cid    = src_to_cid(mshr_source_i);
    assign w_mask       = dir_sharers_i & ~(CORES'(1) << w_req_cid);
    assign w_cand       = mshr_pending_i & ~r_issued;
    assign w_tgt_onehot = CORES'(1) << w_tgt_idx;
    // Leave PROBE in the same cycle the final probe is accepted.
    assign w_last_probe = (w_cand & ~w_tgt_onehot) == '0;

    rv64g_l2_prio_enc #(
        .N     (CORES),
        .IDX_W (CID_W)
    ) u_prio_enc (
        .i_req   (w_cand),
        .o_idx   (w_tgt_idx),
        .o_found (w_tgt_found)
    );

    // ProbeAcks are forwarded in any active state, but only for cores still pending.
    assign w_ack_hit           = (r_state != ST_IDLE) && c_ack_valid_i && mshr_pending_i[c_ack_core_i];
    assign mshr_probe_ack_o    = w_ack_hit;
    assign mshr_probe_ack_id_o = w_ack_hit ? c_ack_core_i : '0;

    assign mshr_probes_mask_o = (r_state == ST_DSET) ? w_mask : '0;
    assign b_core_o           = b_valid_o ? w_tgt_idx : '0;
    assign d_source_o         = d_valid_o ? mshr_source_i : '0;
    assign busy_o             = (r_state != ST_IDLE);

`ifdef L2_MSHR_PROBE_TMO_EN
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;

    // Down-counter loaded with all ones on entry to PROBE; reaching zero is the
    // same instant an up-counter from zero would saturate.
    assign w_tmo_hit = ((r_state == ST_PROBE) || (r_state == ST_WAIT)) && (r_tmo_cnt == '0);
    assign timeout_o = r_timeout;

    // Probe timer and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '1;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state != ST_PROBE) && (w_state_nxt == ST_PROBE)) begin
                r_tmo_cnt <= '1;
            end else if (((r_state == ST_PROBE) || (r_state == ST_WAIT)) && (r_tmo_cnt != '0)) begin
                r_tmo_cnt <= r_tmo_cnt - 1'b1;
            end
            if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    logic [TMO_W-1:0] w_unused_tmo;

    assign w_unused_tmo = '0;
    assign w_tmo_hit    = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Probes already handed to channel B for the current transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued <= '0;
        end else if (r_state == ST_DSET) begin
            r_issued <= '0;
        end else if (b_valid_o && b_ready_i) begin
            r_issued <= r_issued | w_tgt_onehot;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt       = r_state;
        acq_ready_o       = 1'b0;
        mshr_alloc_req_o  = 1'b0;
        dir_req_o         = 1'b0;
        mshr_set_probes_o = 1'b0;
        b_valid_o         = 1'b0;
        d_valid_o         = 1'b0;
        mshr_dealloc_o    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                acq_ready_o = mshr_alloc_ready_i;
                if (acq_valid_i && mshr_alloc_ready_i) begin
                    mshr_alloc_req_o = 1'b1;
                    w_state_nxt      = ST_DIR;
                end
            end
            ST_DIR: begin
                dir_req_o   = 1'b1;
                w_state_nxt = ST_DSET;
            end
            ST_DSET: begin
                mshr_set_probes_o = 1'b1;
                w_state_nxt       = (w_mask == '0) ? ST_GRANT : ST_PROBE;
            end
            ST_PROBE: begin
                b_valid_o = w_tgt_found;
                if (w_tmo_hit) begin
                    w_state_nxt = ST_GRANT;
                end else if (!w_tgt_found) begin
                    w_state_nxt = ST_WAIT;
                end else if (b_ready_i && w_last_probe) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_tmo_hit || (mshr_pending_i == '0)) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                d_valid_o = 1'b1;
                if (d_ready_i) begin
                    w_state_nxt = ST_GACK;
                end
            end
            ST_GACK: begin
                if (e_valid_i) begin
                    mshr_dealloc_o = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
